// File: rtl/music_keys_pkg.sv
// Shared definitions for the music-key input path: key count, per-key
// debounce states, the released-level constant and a press-count helper.
package music_keys_pkg;

  localparam int NUM_KEYS = 6;

  // Idle level of an active-low key line. MusicKeysController also uses it.
  localparam logic KEY_RELEASED = 1'b1;

  typedef enum logic [2:0] {
    RELEASED     = 3'd0,
    PRESS_PEND   = 3'd1,
    PRESSED      = 3'd2,
    RELEASE_PEND = 3'd3,
    STUCK        = 3'd4
  } key_state_t;

  // Number of keys committing a press in the same cycle.
  function automatic logic [7:0] countPresses(input logic [NUM_KEYS-1:0] pulses);
    logic [7:0] total;
    total = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      total = total + 8'(pulses[i]);
    end
    return total;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key: 2-FF synchroniser, debounce/stuck FSM, debounce and hold
// counters, and the registered press/release pulses. The FSM only ever
// looks at the second synchroniser stage.
module key_debounce_channel
  import music_keys_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,    // 1..31, limited by the 5-bit counter
  parameter int STUCK_MS    = 10000  // 0 disables stuck detection, max 16383
) (
  input  logic       CLK_1Khz,
  input  logic       reset_n,
  input  logic       rawKey,
  output logic       debouncedKey,
  output logic       pressPulse,
  output logic       releasePulse,
  output key_state_t keyState
);

  localparam logic [4:0]  DEB_TARGET   = 5'(DEBOUNCE_MS);
  localparam logic [14:0] STUCK_TARGET = 15'(STUCK_MS);
  localparam bit          STUCK_EN     = (STUCK_MS != 0);

  logic [1:0]  syncFf;
  logic        syncKey;
  key_state_t  state, stateNext;
  logic [4:0]  cnt, cntNext, cntInc;
  logic [13:0] hold, holdNext, holdSat;
  logic        debNext, pressNext, releaseNext;
  logic        debounceDone, holdReached;

  assign syncKey  = syncFf[1];
  assign keyState = state;

  // Two-stage synchroniser for the asynchronous pin, idling at released.
  always_ff @(posedge CLK_1Khz) begin
    if (!reset_n) begin
      syncFf <= {2{KEY_RELEASED}};
    end else begin
      syncFf <= {syncFf[0], rawKey};
    end
  end

  // Counter arithmetic shared by all states. cnt is zero whenever a new
  // debounce window starts, so cntInc == DEB_TARGET also covers the
  // DEBOUNCE_MS = 1 immediate-commit case.
  assign cntInc       = cnt + 5'd1;
  assign debounceDone = (cntInc == DEB_TARGET);
  assign holdSat      = (hold == 14'h3FFF) ? hold : hold + 14'd1;
  assign holdReached  = STUCK_EN && (({1'b0, hold} + 15'd1) >= STUCK_TARGET);

  // State, counters, debounced level and pulse registers.
  always_ff @(posedge CLK_1Khz) begin
    if (!reset_n) begin
      state        <= RELEASED;
      cnt          <= '0;
      hold         <= '0;
      debouncedKey <= KEY_RELEASED;
      pressPulse   <= 1'b0;
      releasePulse <= 1'b0;
    end else begin
      state        <= stateNext;
      cnt          <= cntNext;
      hold         <= holdNext;
      debouncedKey <= debNext;
      pressPulse   <= pressNext;
      releasePulse <= releaseNext;
    end
  end

  // Next-state logic; pulses default low so each lasts a single cycle.
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    holdNext    = hold;
    debNext     = debouncedKey;
    pressNext   = 1'b0;
    releaseNext = 1'b0;
    case (state)
      RELEASED: begin
        cntNext  = '0;
        holdNext = '0;
        if (!syncKey) begin
          if (debounceDone) begin
            stateNext = PRESSED;
            debNext   = ~KEY_RELEASED;
            pressNext = 1'b1;
          end else begin
            stateNext = PRESS_PEND;
            cntNext   = cntInc;
          end
        end
      end
      PRESS_PEND: begin
        if (syncKey) begin
          stateNext = RELEASED;
          cntNext   = '0;
        end else if (debounceDone) begin
          stateNext = PRESSED;
          cntNext   = '0;
          holdNext  = '0;
          debNext   = ~KEY_RELEASED;
          pressNext = 1'b1;
        end else begin
          cntNext = cntInc;
        end
      end
      PRESSED: begin
        holdNext = holdSat;
        if (syncKey) begin
          if (debounceDone) begin
            stateNext   = RELEASED;
            cntNext     = '0;
            holdNext    = '0;
            debNext     = KEY_RELEASED;
            releaseNext = 1'b1;
          end else begin
            stateNext = RELEASE_PEND;
            cntNext   = cntInc;
          end
        end else if (holdReached) begin
          // Jammed key: drop the note now, wait for a clean release later.
          stateNext   = STUCK;
          cntNext     = '0;
          debNext     = KEY_RELEASED;
          releaseNext = 1'b1;
        end
      end
      RELEASE_PEND: begin
        holdNext = holdSat;
        if (!syncKey) begin
          stateNext = PRESSED;
          cntNext   = '0;
        end else if (debounceDone) begin
          stateNext   = RELEASED;
          cntNext     = '0;
          holdNext    = '0;
          debNext     = KEY_RELEASED;
          releaseNext = 1'b1;
        end else begin
          cntNext = cntInc;
        end
      end
      STUCK: begin
        debNext = KEY_RELEASED;
        if (!syncKey) begin
          cntNext = '0;
        end else if (debounceDone) begin
          stateNext = RELEASED;
          cntNext   = '0;
          holdNext  = '0;
        end else begin
          cntNext = cntInc;
        end
      end
      default: begin
        stateNext = RELEASED;
        cntNext   = '0;
        holdNext  = '0;
        debNext   = KEY_RELEASED;
      end
    endcase
  end

endmodule

// File: rtl/music_key_debouncer.sv
// Conditioning stage for the six active-low music keys: one debounce
// channel per key, a running press counter and the debug word.
module music_key_debouncer
  import music_keys_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int STUCK_MS    = 10000
) (
  input  logic                CLK_1Khz,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] raw_MusicKey,
  output logic [NUM_KEYS-1:0] debounced_MusicKey,
  output logic [NUM_KEYS-1:0] keyPressPulse,
  output logic [NUM_KEYS-1:0] keyReleasePulse,
  output logic [NUM_KEYS-1:0] keyStuck,
  output logic [31:0]         debugString
);

  key_state_t chanState [NUM_KEYS];
  logic [7:0] pressCount;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_channel #(
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .STUCK_MS   (STUCK_MS)
    ) u_channel (
      .CLK_1Khz    (CLK_1Khz),
      .reset_n     (reset_n),
      .rawKey      (raw_MusicKey[i]),
      .debouncedKey(debounced_MusicKey[i]),
      .pressPulse  (keyPressPulse[i]),
      .releasePulse(keyReleasePulse[i]),
      .keyState    (chanState[i])
    );
  end

  // Stuck flag comes straight from each channel's registered state.
  always_comb begin
    keyStuck = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      keyStuck[i] = (chanState[i] == STUCK);
    end
  end

  // Running count of committed presses, wrapping modulo 256.
  always_ff @(posedge CLK_1Khz) begin
    if (!reset_n) begin
      pressCount <= '0;
    end else begin
      pressCount <= pressCount + countPresses(keyPressPulse);
    end
  end

  assign debugString = {8'h00, pressCount, 2'b00, keyStuck, 2'b00, debounced_MusicKey};

endmodule

// File: tb/tb_music_key_debouncer.sv
// Bench for music_key_debouncer: table of key steps with scoreboarded
// event timing, hand sequences for bounce, stuck, reset and wrap, plus a
// second instance with single-sample debounce.
module tb_music_key_debouncer;
  import music_keys_pkg::*;

  localparam int DEB = 20;
  localparam int STK = 100;
  localparam int LAT = 2 + DEB;

  logic        CLK_1Khz = 1'b0;
  logic        reset_n  = 1'b0;
  logic [5:0]  raw_MusicKey = 6'h3F;
  logic [5:0]  debounced_MusicKey, keyPressPulse, keyReleasePulse, keyStuck;
  logic [31:0] debugString;

  logic [5:0]  rawB = 6'h3F;
  logic [5:0]  debB, pressB, releaseB, stuckB;
  logic [31:0] debugB;

  music_key_debouncer #(.DEBOUNCE_MS(DEB), .STUCK_MS(STK)) dut (
    .CLK_1Khz          (CLK_1Khz),
    .reset_n           (reset_n),
    .raw_MusicKey      (raw_MusicKey),
    .debounced_MusicKey(debounced_MusicKey),
    .keyPressPulse     (keyPressPulse),
    .keyReleasePulse   (keyReleasePulse),
    .keyStuck          (keyStuck),
    .debugString       (debugString)
  );

  music_key_debouncer #(.DEBOUNCE_MS(1), .STUCK_MS(0)) dut_fast (
    .CLK_1Khz          (CLK_1Khz),
    .reset_n           (reset_n),
    .raw_MusicKey      (rawB),
    .debounced_MusicKey(debB),
    .keyPressPulse     (pressB),
    .keyReleasePulse   (releaseB),
    .keyStuck          (stuckB),
    .debugString       (debugB)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 CLK_1Khz = ~CLK_1Khz;

  int cycle = 0;
  always @(posedge CLK_1Khz) cycle <= cycle + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] cyc;
    logic [5:0]  press;
    logic [5:0]  rel;
    logic [5:0]  deb;
    logic [5:0]  stuck;
  } evt_t;

  evt_t exp_q[$];
  evt_t got_evt;

  task automatic expect_evt(input int lat, input logic [5:0] press, input logic [5:0] rel,
                            input logic [5:0] deb, input logic [5:0] stuck);
    exp_q.push_back('{cyc: 32'(cycle + lat), press: press, rel: rel, deb: deb, stuck: stuck});
  endtask

  // Every pulse cycle must match the oldest expected event; expected
  // events whose cycle has passed without a pulse are reported as missed.
  always @(negedge CLK_1Khz) begin
    if (reset_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < 32'(cycle)) begin
        got_evt = exp_q.pop_front();
        check("missed_event_cycle", 32'(cycle), got_evt.cyc);
      end
      if ((|keyPressPulse) || (|keyReleasePulse)) begin
        check("pulse_overlap", {26'b0, keyPressPulse & keyReleasePulse}, 32'h0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {20'b0, keyPressPulse, keyReleasePulse}, 32'h0);
        end else begin
          got_evt = exp_q.pop_front();
          check("event_cycle", 32'(cycle), got_evt.cyc);
          check("event_outputs",
                {8'b0, keyPressPulse, keyReleasePulse, debounced_MusicKey, keyStuck},
                {8'b0, got_evt.press, got_evt.rel, got_evt.deb, got_evt.stuck});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK_1Khz);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_deb"},   {26'b0, debounced_MusicKey}, 32'h3F);
    check({tag, "_press"}, {26'b0, keyPressPulse}, 32'h0);
    check({tag, "_rel"},   {26'b0, keyReleasePulse}, 32'h0);
    check({tag, "_stuck"}, {26'b0, keyStuck}, 32'h0);
    check({tag, "_debug"}, debugString, 32'h0000003F);
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [5:0] raw;
    int         holdCyc;
    logic [5:0] press;
    logic [5:0] rel;
    logic [5:0] deb;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{6'h3E, 60, 6'h01, 6'h00, 6'h3E};  // clean press key 0
    vecs[1] = '{6'h3F, 60, 6'h00, 6'h01, 6'h3F};  // clean release key 0
    vecs[2] = '{6'h00, 60, 6'h3F, 6'h00, 6'h00};  // all keys together
    vecs[3] = '{6'h3F, 60, 6'h00, 6'h3F, 6'h3F};  // release all together
    vecs[4] = '{6'h35, 60, 6'h0A, 6'h00, 6'h35};  // keys 1 and 3
    vecs[5] = '{6'h3F, 60, 6'h00, 6'h0A, 6'h3F};
    vecs[6] = '{6'h3B, 10, 6'h00, 6'h00, 6'h3F};  // 10-cycle glitch on key 2
    vecs[7] = '{6'h3F, 40, 6'h00, 6'h00, 6'h3F};

    @(negedge CLK_1Khz);
    reset_n = 1'b0;
    wait_cycles(3);
    check_cleared("reset");
    check("reset_fast_deb", {26'b0, debB}, 32'h3F);
    reset_n = 1'b1;
    wait_cycles(2);

    // Table-driven steps; pressCount = 1 + 6 + 2 afterwards.
    for (int v = 0; v < 8; v++) begin
      raw_MusicKey = vecs[v].raw;
      if ((vecs[v].press | vecs[v].rel) != 6'h00)
        expect_evt(LAT, vecs[v].press, vecs[v].rel, vecs[v].deb, 6'h00);
      wait_cycles(vecs[v].holdCyc);
      check("vec_deb", {26'b0, debounced_MusicKey}, {26'b0, vecs[v].deb});
    end
    check("table_debug", debugString, 32'h0009003F);

    // Bounce on key 2: 5-cycle toggles, then a clean settle at 0.
    for (int k = 0; k < 12; k++) begin
      raw_MusicKey[2] = k[0];
      wait_cycles(5);
    end
    check("bounce_quiet", {26'b0, debounced_MusicKey}, 32'h3F);
    raw_MusicKey[2] = 1'b0;
    expect_evt(LAT, 6'h04, 6'h00, 6'h3B, 6'h00);
    wait_cycles(40);
    check("bounce_deb", {26'b0, debounced_MusicKey}, 32'h3B);
    raw_MusicKey = 6'h3F;
    expect_evt(LAT, 6'h00, 6'h04, 6'h3F, 6'h00);
    wait_cycles(40);
    check("bounce_count", {24'b0, debugString[23:16]}, 32'd10);

    // Stuck key 4: forced release STK cycles after the press commit.
    raw_MusicKey[4] = 1'b0;
    expect_evt(LAT, 6'h10, 6'h00, 6'h2F, 6'h00);
    expect_evt(LAT + STK, 6'h00, 6'h10, 6'h3F, 6'h10);
    wait_cycles(130);
    check("stuck_debug", debugString, 32'h000B103F);
    raw_MusicKey = 6'h3F;
    wait_cycles(LAT - 1);
    check("stuck_held", {26'b0, keyStuck}, 32'h10);
    wait_cycles(1);
    check("stuck_cleared", {26'b0, keyStuck}, 32'h0);
    wait_cycles(10);

    // Reset while key 5 is pending.
    raw_MusicKey[5] = 1'b0;
    wait_cycles(10);
    reset_n = 1'b0;
    raw_MusicKey = 6'h3F;
    wait_cycles(1);
    check_cleared("rst_pend");
    reset_n = 1'b1;
    wait_cycles(2);

    // Reset while key 5 is held.
    raw_MusicKey[5] = 1'b0;
    expect_evt(LAT, 6'h20, 6'h00, 6'h1F, 6'h00);
    wait_cycles(30);
    check("rst_pressed_before", {24'b0, debugString[23:16]}, 32'd1);
    reset_n = 1'b0;
    raw_MusicKey = 6'h3F;
    wait_cycles(1);
    check_cleared("rst_pressed");
    reset_n = 1'b1;
    wait_cycles(2);

    // 260 presses on key 1: counter wraps to 4.
    for (int n = 0; n < 260; n++) begin
      raw_MusicKey[1] = 1'b0;
      expect_evt(LAT, 6'h02, 6'h00, 6'h3D, 6'h00);
      wait_cycles(30);
      raw_MusicKey[1] = 1'b1;
      expect_evt(LAT, 6'h00, 6'h02, 6'h3F, 6'h00);
      wait_cycles(30);
    end
    check("press_count_wrap", {24'b0, debugString[23:16]}, 32'd4);

    // Single-sample debounce, stuck detection disabled.
    rawB[3] = 1'b0;
    wait_cycles(2);
    check("fast_before", {20'b0, debB, pressB}, {20'b0, 6'h3F, 6'h00});
    wait_cycles(1);
    check("fast_press", {20'b0, debB, pressB}, {20'b0, 6'h37, 6'h08});
    wait_cycles(1);
    check("fast_pulse_one", {26'b0, pressB}, 32'h0);
    wait_cycles(200);
    check("fast_no_stuck", {20'b0, debB, stuckB}, {20'b0, 6'h37, 6'h00});
    rawB = 6'h3F;
    wait_cycles(3);
    check("fast_release", {20'b0, debB, releaseB}, {20'b0, 6'h3F, 6'h08});

    wait_cycles(5);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
